ctrl_pipe: RTL and testbench

//  Receiving end of the ID-stage control bundle. Carries the 10-bit ctrl bundle through the EX, MEM and WB pipeline registers.

---
 rtl/ctrl_pipe_if.sv | 48 ++++
 rtl/ctrl_pipe.sv | 127 ++++++++++++
 tb/tb_ctrl_pipe.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_if.sv
// Control-pipe bus: ID-stage bundle in, per-stage control and
// forwarding info plus stall/flush statistics out.
interface ctrl_pipe_if #(
   parameter int CNT_W = 16
);
   logic [9:0]       ctrl_signal_i;
   logic [4:0]       id_rs_i;
   logic [4:0]       id_rt_i;
   logic [4:0]       id_rd_i;
   logic             flush_i;
   logic             stall_o;
   logic [1:0]       ex_alu_op_o;
   logic             ex_reg_dst_o;
   logic             ex_alu_src_o;
   logic             ex_reg_write_o;
   logic [4:0]       ex_write_reg_o;
   logic             mem_mem_write_o;
   logic             mem_mem_read_o;
   logic             mem_reg_write_o;
   logic [4:0]       mem_write_reg_o;
   logic             wb_mem_to_reg_o;
   logic             wb_reg_write_o;
   logic [4:0]       wb_write_reg_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport slave (
      input  ctrl_signal_i, id_rs_i, id_rt_i, id_rd_i, flush_i,
      output stall_o,
      output ex_alu_op_o, ex_reg_dst_o, ex_alu_src_o,
      output ex_reg_write_o, ex_write_reg_o,
      output mem_mem_write_o, mem_mem_read_o,
      output mem_reg_write_o, mem_write_reg_o,
      output wb_mem_to_reg_o, wb_reg_write_o, wb_write_reg_o,
      output stall_cnt_o, flush_cnt_o
   );

   modport master (
      output ctrl_signal_i, id_rs_i, id_rt_i, id_rd_i, flush_i,
      input  stall_o,
      input  ex_alu_op_o, ex_reg_dst_o, ex_alu_src_o,
      input  ex_reg_write_o, ex_write_reg_o,
      input  mem_mem_write_o, mem_mem_read_o,
      input  mem_reg_write_o, mem_write_reg_o,
      input  wb_mem_to_reg_o, wb_reg_write_o, wb_write_reg_o,
      input  stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/ctrl_pipe.sv
// EX/MEM/WB control pipeline with load-use stall, flush bubble
// and saturating stall/flush counters.
module ctrl_pipe #(
   parameter int CNT_W = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   ctrl_pipe_if.slave  bus
);

   typedef struct packed {
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
      logic [4:0] dst;
   } ex_t;

   typedef struct packed {
      logic       mem_write;
      logic       mem_read;
      logic       mem_to_reg;
      logic       reg_write;
      logic [4:0] dst;
   } mem_t;

   typedef struct packed {
      logic       mem_to_reg;
      logic       reg_write;
      logic [4:0] dst;
   } wb_t;

   ex_t              ex_q, ex_d;
   mem_t             mem_q, mem_d;
   wb_t              wb_q, wb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [9:0] ctrl;
   logic       uses_rt;
   logic       hazard;
   logic       stall;
   logic       bubble;
   logic [4:0] id_dst;
   logic       unused_jump;

   assign ctrl        = bus.ctrl_signal_i;
   // Jump is resolved in ID and never stored.
   assign unused_jump = ctrl[0];

   always_comb begin
      uses_rt = ctrl[7] | ctrl[3] | ctrl[1];
      hazard  = ex_q.mem_read & ex_q.reg_write &
                ((ex_q.dst == bus.id_rs_i) |
                 (uses_rt & (ex_q.dst == bus.id_rt_i)));
      stall   = ~bus.flush_i & hazard;
      bubble  = stall | bus.flush_i;
      id_dst  = ctrl[7] ? bus.id_rd_i : bus.id_rt_i;

      ex_d = '0;
      if (!bubble) begin
         ex_d.alu_op     = ctrl[9:8];
         ex_d.reg_dst    = ctrl[7];
         ex_d.alu_src    = ctrl[6];
         ex_d.mem_to_reg = ctrl[5];
         // Writes to $0 are dropped at capture.
         ex_d.reg_write  = ctrl[4] & (id_dst != 5'd0);
         ex_d.mem_write  = ctrl[3];
         ex_d.mem_read   = ctrl[2];
         ex_d.dst        = id_dst;
      end

      mem_d.mem_write  = ex_q.mem_write;
      mem_d.mem_read   = ex_q.mem_read;
      mem_d.mem_to_reg = ex_q.mem_to_reg;
      mem_d.reg_write  = ex_q.reg_write;
      mem_d.dst        = ex_q.dst;

      wb_d.mem_to_reg = mem_q.mem_to_reg;
      wb_d.reg_write  = mem_q.reg_write;
      wb_d.dst        = mem_q.dst;

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);

      flush_cnt_d = flush_cnt_q;
      if (bus.flush_i && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.stall_o         = stall;
   assign bus.ex_alu_op_o     = ex_q.alu_op;
   assign bus.ex_reg_dst_o    = ex_q.reg_dst;
   assign bus.ex_alu_src_o    = ex_q.alu_src;
   assign bus.ex_reg_write_o  = ex_q.reg_write;
   assign bus.ex_write_reg_o  = ex_q.dst;
   assign bus.mem_mem_write_o = mem_q.mem_write;
   assign bus.mem_mem_read_o  = mem_q.mem_read;
   assign bus.mem_reg_write_o = mem_q.reg_write;
   assign bus.mem_write_reg_o = mem_q.dst;
   assign bus.wb_mem_to_reg_o = wb_q.mem_to_reg;
   assign bus.wb_reg_write_o  = wb_q.reg_write;
   assign bus.wb_write_reg_o  = wb_q.dst;
   assign bus.stall_cnt_o     = stall_cnt_q;
   assign bus.flush_cnt_o     = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a 16-bit-counter and a
// 2-bit-counter instance share the same stimulus.
module tb_ctrl_pipe;

   localparam logic [9:0] R_T  = 10'b11_1_0_0_1_0_0_0_0;
   localparam logic [9:0] LW   = 10'b00_0_1_1_1_0_1_0_0;
   localparam logic [9:0] SW   = 10'b00_0_1_0_0_1_0_0_0;
   localparam logic [9:0] ADDI = 10'b00_0_1_0_1_0_0_0_0;
   localparam logic [9:0] NOP  = 10'b0;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   ctrl_pipe_if #(.CNT_W(16)) b16 ();
   ctrl_pipe_if #(.CNT_W(2))  b2 ();

   ctrl_pipe #(.CNT_W(16)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (b16)
   );

   ctrl_pipe #(.CNT_W(2)) dut2 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (b2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [9:0] c,
                        input logic [4:0] rs,
                        input logic [4:0] rt,
                        input logic [4:0] rd,
                        input logic       fl);
      b16.ctrl_signal_i = c;
      b16.id_rs_i       = rs;
      b16.id_rt_i       = rt;
      b16.id_rd_i       = rd;
      b16.flush_i       = fl;
      b2.ctrl_signal_i  = c;
      b2.id_rs_i        = rs;
      b2.id_rt_i        = rt;
      b2.id_rd_i        = rd;
      b2.flush_i        = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;

      // reset with an R-type sitting in ID
      rst = 1'b1;
      drive(R_T, 5'd1, 5'd2, 5'd3, 1'b0);
      tick();
      tick();
      #1;
      chk("rst_stall", 32'(b16.stall_o), 32'd0);
      chk("rst_ex_op", 32'(b16.ex_alu_op_o), 32'd0);
      chk("rst_ex_rw", 32'(b16.ex_reg_write_o), 32'd0);
      chk("rst_ex_wr", 32'(b16.ex_write_reg_o), 32'd0);
      chk("rst_mem_rw", 32'(b16.mem_reg_write_o), 32'd0);
      chk("rst_wb_rw", 32'(b16.wb_reg_write_o), 32'd0);
      chk("rst_scnt", 32'(b16.stall_cnt_o), 32'd0);
      chk("rst_fcnt", 32'(b16.flush_cnt_o), 32'd0);
      rst = 1'b0;

      // R-type through the pipe
      drive(R_T, 5'd1, 5'd2, 5'd3, 1'b0);
      tick();
      chk("r_ex_op", 32'(b16.ex_alu_op_o), 32'd3);
      chk("r_ex_dst", 32'(b16.ex_reg_dst_o), 32'd1);
      chk("r_ex_wr", 32'(b16.ex_write_reg_o), 32'd3);
      chk("r_ex_rw", 32'(b16.ex_reg_write_o), 32'd1);
      drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
      chk("r_mem_rw", 32'(b16.mem_reg_write_o), 32'd1);
      chk("r_mem_wr", 32'(b16.mem_write_reg_o), 32'd3);
      chk("r_ex_nop", 32'(b16.ex_reg_write_o), 32'd0);
      tick();
      chk("r_wb_rw", 32'(b16.wb_reg_write_o), 32'd1);
      chk("r_wb_wr", 32'(b16.wb_write_reg_o), 32'd3);
      chk("r_wb_m2r", 32'(b16.wb_mem_to_reg_o), 32'd0);

      // lw rt=5 then R-type rs=5: one-cycle stall
      drive(LW, 5'd1, 5'd5, 5'd0, 1'b0);
      tick();
      chk("lw_ex_rd", 32'(b16.ex_write_reg_o), 32'd5);
      drive(R_T, 5'd5, 5'd2, 5'd6, 1'b0);
      #1;
      chk("lu_stall", 32'(b16.stall_o), 32'd1);
      tick();
      chk("lu_ex_rw", 32'(b16.ex_reg_write_o), 32'd0);
      chk("lu_ex_op", 32'(b16.ex_alu_op_o), 32'd0);
      chk("lu_ex_wr", 32'(b16.ex_write_reg_o), 32'd0);
      chk("lu_scnt", 32'(b16.stall_cnt_o), 32'd1);
      chk("lu_mem_rd", 32'(b16.mem_mem_read_o), 32'd1);
      chk("lu_stall2", 32'(b16.stall_o), 32'd0);
      tick();
      chk("lu_ex_op2", 32'(b16.ex_alu_op_o), 32'd3);
      chk("lu_ex_wr2", 32'(b16.ex_write_reg_o), 32'd6);
      chk("lu_scnt2", 32'(b16.stall_cnt_o), 32'd1);

      // lw rt=5 then sw rt=5: stall via rt
      drive(LW, 5'd1, 5'd5, 5'd0, 1'b0);
      tick();
      drive(SW, 5'd1, 5'd5, 5'd0, 1'b0);
      #1;
      chk("sw_stall", 32'(b16.stall_o), 32'd1);
      tick();
      chk("sw_scnt", 32'(b16.stall_cnt_o), 32'd2);
      tick();
      chk("sw_ex_mw", 32'(b16.ex_alu_src_o), 32'd1);

      // lw rt=5 then addi rs=1 rt=5: rt is a dest only
      drive(LW, 5'd1, 5'd5, 5'd0, 1'b0);
      tick();
      drive(ADDI, 5'd1, 5'd5, 5'd0, 1'b0);
      #1;
      chk("addi_nostall", 32'(b16.stall_o), 32'd0);
      tick();
      chk("addi_ex_wr", 32'(b16.ex_write_reg_o), 32'd5);
      chk("addi_scnt", 32'(b16.stall_cnt_o), 32'd2);

      // hazard with flush: flush wins
      drive(LW, 5'd1, 5'd5, 5'd0, 1'b0);
      tick();
      drive(R_T, 5'd5, 5'd2, 5'd6, 1'b1);
      #1;
      chk("fl_stall", 32'(b16.stall_o), 32'd0);
      tick();
      chk("fl_ex_rw", 32'(b16.ex_reg_write_o), 32'd0);
      chk("fl_ex_op", 32'(b16.ex_alu_op_o), 32'd0);
      chk("fl_fcnt", 32'(b16.flush_cnt_o), 32'd1);
      chk("fl_scnt", 32'(b16.stall_cnt_o), 32'd2);

      // addi to $0 never writes back
      drive(ADDI, 5'd1, 5'd0, 5'd0, 1'b0);
      tick();
      chk("z_ex_rw", 32'(b16.ex_reg_write_o), 32'd0);
      chk("z_ex_src", 32'(b16.ex_alu_src_o), 32'd1);
      drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
      tick();
      chk("z_wb_rw", 32'(b16.wb_reg_write_o), 32'd0);

      // five more stalls: 2-bit counter saturates at 3
      for (int i = 0; i < 5; i++) begin
         drive(LW, 5'd1, 5'd5, 5'd0, 1'b0);
         tick();
         drive(R_T, 5'd5, 5'd2, 5'd6, 1'b0);
         #1;
         chk("sat_stall", 32'(b16.stall_o), 32'd1);
         tick();
      end
      chk("sat_scnt16", 32'(b16.stall_cnt_o), 32'd7);
      chk("sat_scnt2", 32'(b2.stall_cnt_o), 32'd3);
      chk("sat_fcnt2", 32'(b2.flush_cnt_o), 32'd1);

      // reset discards in-flight state
      drive(R_T, 5'd1, 5'd2, 5'd3, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      chk("rst2_ex_rw", 32'(b16.ex_reg_write_o), 32'd0);
      chk("rst2_mem_rw", 32'(b16.mem_reg_write_o), 32'd0);
      chk("rst2_scnt", 32'(b16.stall_cnt_o), 32'd0);
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
